neuron_mac: RTL

NEURON_MAC -- requirements
Module: neuron_mac

---
 rtl/neuron_mac.sv | 118 +++++++++++
 1 files changed

// File: rtl/neuron_mac.sv
// Eight-element weighted-sum neuron: accepts a frame of activations over a valid/ready
// handshake, accumulates data*weight with saturation, and reports the sum and a fire flag.
//
// state | meaning
// IDLE  | waiting for element 0; last result retained on sum_o/fire_o
// ACCUM | elements 1..7 being accumulated against the captured weights
// DONE  | result presented on out_valid_o until the consumer takes it

module neuron_mac #(
  parameter int                     WIDTH_P     = 8,
  parameter int                     ACC_WIDTH_P = 16,
  parameter logic [ACC_WIDTH_P-1:0] THRESHOLD_P = 16'd4000
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [WIDTH_P-1:0]     weight_0,
  input  logic [WIDTH_P-1:0]     weight_1,
  input  logic [WIDTH_P-1:0]     weight_2,
  input  logic [WIDTH_P-1:0]     weight_3,
  input  logic [WIDTH_P-1:0]     weight_4,
  input  logic [WIDTH_P-1:0]     weight_5,
  input  logic [WIDTH_P-1:0]     weight_6,
  input  logic [WIDTH_P-1:0]     weight_7,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [WIDTH_P-1:0]     in_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [ACC_WIDTH_P-1:0] sum_o,
  output logic                   fire_o,
  output logic                   busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                 state;
  logic [WIDTH_P-1:0]     w_live [8];
  logic [WIDTH_P-1:0]     w_cap  [8];
  logic [2:0]             idx;
  logic [ACC_WIDTH_P-1:0] acc;

  logic                   accept;
  logic [WIDTH_P-1:0]     w_sel;
  logic [2*WIDTH_P-1:0]   prod;
  logic [ACC_WIDTH_P-1:0] prod_ext;
  logic [ACC_WIDTH_P-1:0] acc_base;
  logic [ACC_WIDTH_P:0]   sum_wide;
  logic [ACC_WIDTH_P-1:0] acc_next;

  assign w_live = '{weight_0, weight_1, weight_2, weight_3,
                    weight_4, weight_5, weight_6, weight_7};

  // Element 0 multiplies by the live weight_0 because the capture happens on that same edge.
  always_comb begin
    in_ready_o = (state != DONE);
    accept     = in_valid_i & in_ready_o;
    w_sel      = (state == IDLE) ? w_live[0] : w_cap[idx];
    acc_base   = (state == IDLE) ? '0 : acc;
    prod       = {{WIDTH_P{1'b0}}, in_data_i} * {{WIDTH_P{1'b0}}, w_sel};
    prod_ext   = ACC_WIDTH_P'(prod);
    sum_wide   = {1'b0, acc_base} + {1'b0, prod_ext};
    acc_next   = sum_wide[ACC_WIDTH_P] ? '1 : sum_wide[ACC_WIDTH_P-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      acc         <= '0;
      idx         <= '0;
      sum_o       <= '0;
      fire_o      <= 1'b0;
      out_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      for (int i = 0; i < 8; i++) w_cap[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            w_cap  <= w_live;
            acc    <= acc_next;
            idx    <= 3'd1;
            state  <= ACCUM;
            busy_o <= 1'b1;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc <= acc_next;
            idx <= idx + 3'd1;
            if (idx == 3'd7) begin
              state       <= DONE;
              busy_o      <= 1'b0;
              out_valid_o <= 1'b1;
              sum_o       <= acc_next;
              fire_o      <= (acc_next >= THRESHOLD_P);
            end
          end
        end
        DONE: begin
          if (out_ready_i) begin
            state       <= IDLE;
            out_valid_o <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          busy_o      <= 1'b0;
          out_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
